au_neg_seq: RTL

//   Digit-serial 2's complementer/absolute-value unit with valid/ready handshakes.

---
 rtl/au_neg_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/au_neg_seq.sv
// rtl/au_neg_seq.sv - digit-serial 2's complementer / absolute-value unit
//
// Purpose:
//   Accepts one WIDTH-bit word per handshake and resolves its negation (or
//   absolute value) DIGIT bits per cycle, LSB first. The "all lower bits zero"
//   carry is kept between digits. The full result is returned in one beat.
//   Cycle count depends only on WIDTH/DIGIT: accept edge t -> out_valid after
//   edge t+NDIG.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      unit can accept a word (IDLE only)
//   in_a       in   WIDTH  input word, 2's complement
//   in_abs     in   1      0: z = -a, 1: z = |a|
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      downstream accepts result
//   out_z      out  WIDTH  result modulo 2^WIDTH
//   out_ovf    out  1      negation applied to 100..0
//   busy       out  1      state != IDLE
module au_neg_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_abs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_z;
  logic             r_neg;
  logic             r_p;
  logic             r_ovf;
  logic [KW-1:0]    r_k;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_dig;
  logic [DIGIT-1:0] w_dz;
  logic             w_c;
  logic [WIDTH-1:0] w_fin;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_RUN) && (r_k == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Gather digit k of the operand; bits beyond WIDTH in a partial last
  // digit read as zero.
  always_comb begin
    w_dig = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (KW'(i / DIGIT) == r_k) w_dig[i % DIGIT] = r_a[i];
    end
  end

  // Ripple the "all lower bits zero" carry across the digit. A bit is
  // inverted unless every lower bit of the word is zero.
  always_comb begin
    w_c  = r_p;
    w_dz = '0;
    for (int j = 0; j < DIGIT; j++) begin
      w_dz[j] = r_neg ? (~w_dig[j] ^ w_c) : w_dig[j];
      w_c     = w_c & ~w_dig[j];
    end
  end

  // Working result with the current digit merged in.
  always_comb begin
    w_fin = r_w;
    for (int i = 0; i < WIDTH; i++) begin
      if (KW'(i / DIGIT) == r_k) w_fin[i] = w_dz[i % DIGIT];
    end
  end

  // out_z only updates on the last digit so it holds the previous result
  // while a new word is in flight. Overflow: a negated word whose sign stays
  // set can only be 100..0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_w   <= '0;
      r_z   <= '0;
      r_neg <= 1'b0;
      r_p   <= 1'b0;
      r_ovf <= 1'b0;
      r_k   <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_neg <= in_abs ? in_a[WIDTH-1] : 1'b1;
      r_p   <= 1'b1;
      r_k   <= '0;
    end else if (r_state == S_RUN) begin
      r_w <= w_fin;
      r_p <= w_c;
      r_k <= r_k + KW'(1);
      if (w_last) begin
        r_z   <= w_fin;
        r_ovf <= r_neg & r_a[WIDTH-1] & w_fin[WIDTH-1];
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_z     = r_z;
  assign out_ovf   = r_ovf;

endmodule
